// File: rtl/aes_inv_round_data.sv
// aes_inv_round_data
// One AES inverse-cipher round per clock with a registered result. The step
// applied depends on the round index and key-length mode:
//   round == 0        : InvSubBytes(InvShiftRows(data_in ^ round_key))
//   0 < round < Nr    : InvSubBytes(InvShiftRows(InvMixColumns(data_in ^ round_key)))
//   round >= Nr       : data_in ^ round_key   (final AddRoundKey, plaintext)
// Nr is 10/12/14 for mode 00/01/10, and mode 11 behaves like mode 00.
// The caller sequences rounds, supplies round keys in reverse order and
// feeds data_out back into data_in.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears data_out, valid_out)
//   valid_in   round/mode/round_key/data_in are valid this cycle
//   round      inverse-round index (0 = first decryption step)
//   mode       key length select
//   round_key  expanded key[Nr - round]
//   data_in    input state, byte 0 in bits [127:120], column-major
//   data_out   registered result state (held while valid_in is low)
//   valid_out  data_out was produced by the previous cycle's valid_in
module aes_inv_round_data (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [3:0]   round,
  input  logic [1:0]   mode,
  input  logic [127:0] round_key,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         valid_out
);

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sub(input logic [7:0] b);
    inv_sub = INV_SBOX[b];
  endfunction

  // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column times the circulant [0e 0b 0d 09]; row 0 sits in bits [31:24].
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [0:3];
    logic [7:0] x2 [0:3];
    logic [7:0] x4 [0:3];
    logic [7:0] x8 [0:3];
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])                   // 0e
                       ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])  // 0b
                       ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])  // 0d
                       ^ (x8[(r+3)%4] ^ a[(r+3)%4]);               // 09
    end
    inv_mix_col = res;
  endfunction

  logic [3:0]   nr_s;
  logic [127:0] ark_s;
  logic [127:0] imc_s;
  logic [127:0] mix_sel_s;
  logic [127:0] isr_s;
  logic [127:0] isb_s;
  logic [127:0] result_s;

  // Number of rounds for the selected key length; the reserved code maps to AES-128.
  always_comb begin
    nr_s = 4'd10;
    case (mode)
      2'b01:   nr_s = 4'd12;
      2'b10:   nr_s = 4'd14;
      default: nr_s = 4'd10;
    endcase
  end

  // AddRoundKey followed by InvMixColumns on every column.
  always_comb begin
    ark_s = data_in ^ round_key;
    imc_s = '0;
    for (int c = 0; c < 4; c++) begin
      imc_s[127-32*c -: 32] = inv_mix_col(ark_s[127-32*c -: 32]);
    end
  end

  // The first step skips InvMixColumns; every other full round uses it.
  always_comb begin
    mix_sel_s = '0;
    if (round == 4'd0) begin
      mix_sel_s = ark_s;
    end else begin
      mix_sel_s = imc_s;
    end
  end

  // InvShiftRows (row r rotated right by r) then InvSubBytes on all 16 bytes.
  always_comb begin
    isr_s = '0;
    isb_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr_s[127-8*(4*c+r) -: 8] = mix_sel_s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      isb_s[127-8*i -: 8] = inv_sub(isr_s[127-8*i -: 8]);
    end
  end

  // Any round index at or beyond Nr is the final AddRoundKey-only step.
  always_comb begin
    result_s = '0;
    if (round >= nr_s) begin
      result_s = ark_s;
    end else begin
      result_s = isb_s;
    end
  end

  // Output register: capture on valid_in, otherwise hold the last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= 128'h0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        data_out <= result_s;
      end else begin
        data_out <= data_out;
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_round_data.sv
// Self-checking bench for aes_inv_round_data. The reference model builds the
// S-boxes from GF(2^8) inversion plus the affine map, expands keys itself and
// applies the inverse round steps on a byte-array view of the state.
module tb_aes_inv_round_data;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid_in = 1'b0;
  logic [3:0]   round = 4'd0;
  logic [1:0]   mode = 2'b00;
  logic [127:0] round_key = 128'h0;
  logic [127:0] data_in = 128'h0;
  logic [127:0] data_out;
  logic         valid_out;

  int n_vectors = 0;
  int n_miscompares = 0;

  logic [7:0]   sbox_tbl [0:255];
  logic [7:0]   inv_tbl  [0:255];
  logic [127:0] rk       [0:14];
  logic [127:0] exp_data  = 128'h0;
  logic         exp_valid = 1'b0;

  always #5 clk = ~clk;

  aes_inv_round_data dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .round     (round),
    .mode      (mode),
    .round_key (round_key),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Carry-less polynomial product followed by long division by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) prod ^= (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod ^= (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0]  x = ginv(a);
    logic [15:0] d = {x, x};
    logic [7:0]  y = x ^ 8'h63;
    for (int n = 1; n <= 4; n++) y ^= d[15-n -: 8];
    return y;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j <= nr; j++) rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  function automatic logic [127:0] model_round(input logic [127:0] din, input logic [127:0] key,
                                               input logic [3:0] rnd, input logic [1:0] md);
    logic [7:0]   st [0:3][0:3];   // [row][col]
    logic [7:0]   tmp [0:3];
    logic [127:0] s = din ^ key;
    logic [127:0] res = 128'h0;
    int nr = (md == 2'b01) ? 12 : (md == 2'b10) ? 14 : 10;
    if (int'(rnd) >= nr) return s;
    for (int i = 0; i < 16; i++) st[i%4][i/4] = s[127-8*i -: 8];
    if (rnd != 4'd0) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) tmp[r] = st[r][c];
        for (int r = 0; r < 4; r++)
          st[r][c] = gmul(8'h0e, tmp[r]) ^ gmul(8'h0b, tmp[(r+1)%4])
                   ^ gmul(8'h0d, tmp[(r+2)%4]) ^ gmul(8'h09, tmp[(r+3)%4]);
      end
    end
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < r; k++) begin   // rotate row right by one, r times
        logic [7:0] last = st[r][3];
        st[r][3] = st[r][2]; st[r][2] = st[r][1]; st[r][1] = st[r][0]; st[r][0] = last;
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = inv_tbl[st[i%4][i/4]];
    return res;
  endfunction

  task automatic step(input logic v, input logic [3:0] rnd, input logic [1:0] md,
                      input logic [127:0] key, input logic [127:0] din, input string tag);
    valid_in = v; round = rnd; mode = md; round_key = key; data_in = din;
    if (v) exp_data = model_round(din, key, rnd, md);
    exp_valid = v;
    @(posedge clk);
    #1;
    check_vec({tag, "_data"}, data_out, exp_data);
    check_vec({tag, "_valid"}, {127'b0, valid_out}, {127'b0, exp_valid});
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] cur;
  logic [127:0] k;
  logic [127:0] d;

  initial begin
    for (int x = 0; x < 256; x++) sbox_tbl[x] = fwd_sbox(8'(x));
    for (int x = 0; x < 256; x++) inv_tbl[sbox_tbl[x]] = 8'(x);

    // Reset with arbitrary inputs: immediate clear, held through a clock.
    valid_in = 1'b1; round = 4'd3; mode = 2'b01; round_key = rnd128(); data_in = rnd128();
    #2 rst = 1'b1;
    #1;
    check_vec("rst_data", data_out, 128'h0);
    check_vec("rst_valid", {127'b0, valid_out}, 128'h0);
    @(posedge clk); #1;
    check_vec("rst_hold_data", data_out, 128'h0);
    check_vec("rst_hold_valid", {127'b0, valid_out}, 128'h0);
    rst = 1'b0;
    exp_data = 128'h0;
    step(1'b0, 4'd1, 2'b00, rnd128(), rnd128(), "post_rst_idle");

    // AES-128 decryption, all 11 steps back to back.
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    cur = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    for (int r = 0; r <= 10; r++) begin
      step(1'b1, 4'(r), 2'b00, rk[10-r], cur, $sformatf("aes128_r%0d", r));
      case (r)
        0:  check_vec("aes128_r0_known", data_out, 128'hbb36c7eb88334d49a4e7112e74f182c4);
        1:  check_vec("aes128_r1_known", data_out, 128'h41d7c6537d669140dd2f179d02acc51b);
        2:  check_vec("aes128_r2_known", data_out, 128'he26dbb7d40d22134e3b7fda26b9b077c);
        9:  check_vec("aes128_r9_known", data_out, 128'h40bfabf406ee4d3042ca6b997a5c5816);
        10: check_vec("aes128_plain", data_out, 128'h6bc1bee22e409f96e93d7e117393172a);
        default: ;
      endcase
      cur = exp_data;
    end

    // Idle cycles hold data_out and drop valid_out.
    for (int i = 0; i < 3; i++) step(1'b0, 4'(i), 2'(i), rnd128(), rnd128(), "idle_hold");

    // Round/mode bounds.
    k = rnd128(); d = rnd128();
    step(1'b1, 4'd12, 2'b00, k, d, "m00_r12");
    check_vec("m00_r12_xor", data_out, d ^ k);
    step(1'b1, 4'd12, 2'b10, k, d, "m10_r12_full");
    step(1'b1, 4'd15, 2'b10, k, d, "m10_r15");
    check_vec("m10_r15_xor", data_out, d ^ k);
    step(1'b1, 4'd11, 2'b01, k, d, "m01_r11_full");
    step(1'b1, 4'd12, 2'b01, k, d, "m01_r12");
    check_vec("m01_r12_xor", data_out, d ^ k);
    step(1'b1, 4'd10, 2'b11, k, d, "m11_r10");
    check_vec("m11_r10_xor", data_out, d ^ k);
    step(1'b1, 4'd5, 2'b11, k, d, "m11_r5_full");

    // AES-256 decryption (FIPS-197 C.3).
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    cur = 128'h8ea2b7ca516745bfeafc49904b496089;
    for (int r = 0; r <= 14; r++) begin
      step(1'b1, 4'(r), 2'b10, rk[14-r], cur, $sformatf("aes256_r%0d", r));
      cur = exp_data;
    end
    check_vec("aes256_plain", data_out, 128'h00112233445566778899aabbccddeeff);

    // Random rounds, modes and valid patterns.
    for (int i = 0; i < 150; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), rnd128(), rnd128(), "rand");
    end

    // Reset asserted mid-cycle clears outputs at once.
    step(1'b1, 4'd2, 2'b00, rnd128(), rnd128(), "pre_rst");
    #2 rst = 1'b1;
    #1;
    check_vec("midrst_data", data_out, 128'h0);
    check_vec("midrst_valid", {127'b0, valid_out}, 128'h0);
    #6 rst = 1'b0;
    exp_data = 128'h0;
    step(1'b0, 4'd0, 2'b00, rnd128(), rnd128(), "midrst_idle");
    step(1'b1, 4'd0, 2'b00, rnd128(), rnd128(), "midrst_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
